pipe_adder: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor.
//  - Splits a WIDTH-bit add into STAGES carry-chained slices, one slice per clock stage.
//  - valid/ready handshake on input and output; the whole pipe stalls on back-pressure.
//  - Replaces the fixed 32-bit combinational ripple adder in the datapath wherever

---
 rtl/pipe_adder_pkg.sv | 17 +
 rtl/pipe_adder_slice.sv | 27 ++
 rtl/pipe_adder.sv | 171 +++++++++++++++++
 tb/tb_pipe_adder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: slice sizing, geometry check and overflow rule.
package pipe_adder_pkg;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit stages_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_calc(input logic cmsb_in, input logic cmsb_out);
    return cmsb_in ^ cmsb_out;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational SW-bit ripple of full adders; c_msb_in is the carry into the top bit.
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  logic carry;

  always_comb begin
    carry    = ci;
    c_msb_in = 1'b0;
    s        = '0;
    for (int i = 0; i < SW; i++) begin
      s[i] = a[i] ^ b[i] ^ carry;
      if (i == SW - 1) c_msb_in = carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one carry-chained slice per stage, global stall on back-pressure.
// Optional saturation on signed overflow when PIPE_ADDER_SAT_EN is defined (adds port sat).
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] sum_raw;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int ACC_W = (k + 1) * SW;
    localparam int REM_W = WIDTH - ACC_W;

    logic             prev_valid;
    logic             take;
    logic [SW-1:0]    a_sl;
    logic [SW-1:0]    b_sl;
    logic [SW-1:0]    s;
    logic             ci;
    logic             co;
    logic [ACC_W-1:0] acc_next;
    logic             valid;
    logic             carry;
    logic [ACC_W-1:0] sum_acc;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign a_sl       = a[SW-1:0];
      assign b_sl       = b_eff[SW-1:0];
      assign ci         = c0;
      assign acc_next   = s;
    end else begin : g_body
      assign prev_valid = g_stage[k-1].valid;
      assign a_sl       = g_stage[k-1].g_rem.a_rem[SW-1:0];
      assign b_sl       = g_stage[k-1].g_rem.b_rem[SW-1:0];
      assign ci         = g_stage[k-1].carry;
      assign acc_next   = {s, g_stage[k-1].sum_acc};
    end

    // Data only loads with a valid beat, so bubbles leave the previous result in place.
    assign take = adv & prev_valid;

    always_ff @(posedge clk) begin
      if (rst)      valid <= 1'b0;
      else if (adv) valid <= prev_valid;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        carry   <= 1'b0;
        sum_acc <= '0;
      end else if (take) begin
        carry   <= co;
        sum_acc <= acc_next;
      end
    end

    if (k < L) begin : g_rem
      logic [REM_W-1:0] a_rem;
      logic [REM_W-1:0] b_rem;
      logic [REM_W-1:0] a_up;
      logic [REM_W-1:0] b_up;

      if (k == 0) begin : g_src_in
        assign a_up = a[WIDTH-1:SW];
        assign b_up = b_eff[WIDTH-1:SW];
      end else begin : g_src_prev
        assign a_up = g_stage[k-1].g_rem.a_rem[REM_W+SW-1:SW];
        assign b_up = g_stage[k-1].g_rem.b_rem[REM_W+SW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (take) begin
          a_rem <= a_up;
          b_rem <= b_up;
        end
      end
    end

    if (k == L) begin : g_last
      logic c_msb;
      logic cmsb_q;

      add_slice #(.SW(SW)) u_slice (
        .a(a_sl), .b(b_sl), .ci(ci), .s(s), .co(co), .c_msb_in(c_msb)
      );

      always_ff @(posedge clk) begin
        if (rst)       cmsb_q <= 1'b0;
        else if (take) cmsb_q <= c_msb;
      end
    end else begin : g_mid
      logic c_msb_unused;

      add_slice #(.SW(SW)) u_slice (
        .a(a_sl), .b(b_sl), .ci(ci), .s(s), .co(co), .c_msb_in(c_msb_unused)
      );
    end

`ifdef PIPE_ADDER_SAT_EN
    logic sat_q;
    logic prev_sat;

    if (k == 0) begin : g_sat_in
      assign prev_sat = sat;
    end else begin : g_sat_prev
      assign prev_sat = g_stage[k-1].sat_q;
    end

    always_ff @(posedge clk) begin
      if (rst)       sat_q <= 1'b0;
      else if (take) sat_q <= prev_sat;
    end
`endif
  end

  assign out_valid = g_stage[L].valid;
  assign cout      = g_stage[L].carry;
  assign ovf       = ovf_calc(g_stage[L].g_last.cmsb_q, g_stage[L].carry);
  assign sum_raw   = g_stage[L].sum_acc;

`ifdef PIPE_ADDER_SAT_EN
  // A negative-looking raw MSB on overflow means both operands were positive.
  always_comb begin
    sum = sum_raw;
    if (g_stage[L].sat_q && ovf) begin
      sum = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign sum = sum_raw;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed checks on a 32/4 instance, then randomized scoreboards on 32/1, 32/4, 64/8 and 8/8.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_go = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- directed instance, 32/4 ----------------
  logic        d_in_valid = 1'b0, d_in_ready, d_cin = 1'b0, d_sub = 1'b0, d_sat = 1'b0;
  logic        d_out_valid, d_out_ready = 1'b1, d_cout, d_ovf;
  logic [31:0] d_a = '0, d_b = '0, d_sum;

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
`ifdef PIPE_ADDER_SAT_EN
    .sat(d_sat),
`endif
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic sat,
                         input logic [31:0] esum, input logic ecout, input logic eovf);
    int lat;
    @(negedge clk);
    d_a = a; d_b = b; d_cin = cin; d_sub = sub; d_sat = sat;
    d_in_valid = 1'b1; d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 1;
    while (!d_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'd4);
    check_val({tag, "_sum"}, 64'(d_sum), 64'(esum));
    check_val({tag, "_cout"}, 64'(d_cout), 64'(ecout));
    check_val({tag, "_ovf"}, 64'(d_ovf), 64'(eovf));
  endtask

  initial begin : p_main
    logic [31:0] exp_sum [8];
    logic [31:0] held;
    int sent, recv, seen;

    repeat (3) begin
      @(posedge clk); #1;
      check_val("rst_out_valid", 64'(d_out_valid), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst_in_ready", 64'(d_in_ready), 64'd1);
    check_val("post_rst_out_valid", 64'(d_out_valid), 64'd0);

    run_one("add_5_7",   32'd5,          32'd7, 1'b0, 1'b0, 1'b0, 32'd12,         1'b0, 1'b0);
    run_one("carry_x",   32'h0000_FFFF,  32'd1, 1'b0, 1'b0, 1'b0, 32'h0001_0000,  1'b0, 1'b0);
    run_one("sub_3_5",   32'd3,          32'd5, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE,  1'b0, 1'b0);
    run_one("ovf_pos",   32'h7FFF_FFFF,  32'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1);
    run_one("wrap",      32'hFFFF_FFFF,  32'd1, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1, 1'b0);
    run_one("cin_ign",   32'd10,         32'd3, 1'b1, 1'b1, 1'b0, 32'd7,          1'b1, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    run_one("sat_pos",   32'h7FFF_FFFF,  32'd1, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF,  1'b0, 1'b1);
    run_one("sat_neg",   32'h8000_0000,  32'd1, 1'b0, 1'b1, 1'b1, 32'h8000_0000,  1'b1, 1'b1);
`endif
    @(negedge clk);

    // 8 back-to-back beats, downstream stalls on cycles 5..7
    for (int i = 0; i < 8; i++) exp_sum[i] = 32'h1000_0000 * i + 32'h0000_FFFF + (i + 1);
    sent = 0; recv = 0; held = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      @(negedge clk);
      d_cin = 1'b0; d_sub = 1'b0; d_sat = 1'b0;
      d_in_valid  = (sent < 8);
      d_a         = 32'h1000_0000 * sent + 32'h0000_FFFF;
      d_b         = 32'(sent + 1);
      d_out_ready = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) check_val("stall_in_ready", 64'(d_in_ready), 64'd0);
      if (c == 5) held = d_sum;
      if (c == 6 || c == 7) begin
        check_val("stall_valid", 64'(d_out_valid), 64'd1);
        check_val("stall_hold", 64'(d_sum), 64'(held));
      end
      if (d_out_valid && d_out_ready) begin
        check_val("b2b_sum", 64'(d_sum), 64'(exp_sum[recv]));
        recv++;
      end
      if (d_in_valid && d_in_ready) sent++;
    end
    check_val("b2b_count", 64'(recv), 64'd8);

    // flush: reset with three beats in flight
    @(negedge clk);
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in_valid = 1'b1; d_a = 32'(i + 100); d_b = 32'd1;
      @(negedge clk);
    end
    d_in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("flush_now", 64'(d_out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (d_out_valid) seen++;
    end
    check_val("flush_none", 64'(seen), 64'd0);

    rand_go = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      if (g_cfg[0].done_r && g_cfg[1].done_r && g_cfg[2].done_r && g_cfg[3].done_r) break;
    end
    check_val("rand_done0", 64'(g_cfg[0].done_r), 64'd1);
    check_val("rand_done1", 64'(g_cfg[1].done_r), 64'd1);
    check_val("rand_done2", 64'(g_cfg[2].done_r), 64'd1);
    check_val("rand_done3", 64'(g_cfg[3].done_r), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- randomized scoreboards ----------------
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W = (g == 2) ? 64 : (g == 3) ? 8 : 32;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : 8;

    logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0, sat = 1'b0;
    logic         out_valid, out_ready = 1'b1, cout, ovf;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         done_r = 1'b0;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PIPE_ADDER_SAT_EN
      .sat(sat),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Reference: plain (W+1)-bit arithmetic and the sign rule for overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb, input logic st);
      logic [W-1:0] ye, s;
      logic [W:0]   full;
      logic         ov;
      ye   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, ye} + (W+1)'(sb ? 1'b1 : ci);
      s    = full[W-1:0];
      ov   = (x[W-1] == ye[W-1]) && (s[W-1] != x[W-1]);
`ifdef PIPE_ADDER_SAT_EN
      if (st && ov) s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return {ov, full[W], s};
    endfunction

    initial begin : p_rand
      logic [W+1:0] q[$];
      logic [W+1:0] e;
      logic [W-1:0] held;
      logic [63:0]  r;
      logic         hold_chk;
      hold_chk = 1'b0;
      held     = '0;
      wait (rand_go);
      for (int c = 0; c < 460; c++) begin
        @(negedge clk);
        r = {$urandom(), $urandom()}; a = r[W-1:0];
        r = {$urandom(), $urandom()}; b = r[W-1:0];
        if ($urandom_range(0, 7) == 0) b = ~a;
        cin       = 1'($urandom_range(0, 1));
        sub       = 1'($urandom_range(0, 1));
        sat       = 1'($urandom_range(0, 1));
        in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
        out_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
        #1;
        check_val($sformatf("in_ready_w%0d_s%0d", W, S), 64'(in_ready), 64'(!out_valid || out_ready));
        if (hold_chk) begin
          check_val($sformatf("hold_valid_w%0d_s%0d", W, S), 64'(out_valid), 64'd1);
          check_val($sformatf("hold_sum_w%0d_s%0d", W, S), 64'(sum), 64'(held));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check_val($sformatf("extra_emit_w%0d_s%0d", W, S), 64'(out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            check_val($sformatf("sum_w%0d_s%0d", W, S), 64'(sum), 64'(e[W-1:0]));
            check_val($sformatf("cout_w%0d_s%0d", W, S), 64'(cout), 64'(e[W]));
            check_val($sformatf("ovf_w%0d_s%0d", W, S), 64'(ovf), 64'(e[W+1]));
          end
        end
        hold_chk = out_valid && !out_ready;
        held     = sum;
        if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, sat));
      end
      check_val($sformatf("drain_w%0d_s%0d", W, S), 64'(q.size()), 64'd0);
      done_r = 1'b1;
    end
  end

endmodule
